// File: rtl/branch_predictor_pkg.sv
// Shared types, constants and counter helpers for the branch_predictor slice.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt2_e;

  localparam cnt2_e BHT_RESET_STATE = CNT_WNT;

  localparam int              PC_W       = 32;
  localparam int              PC_IDX_LSB = 2;
  localparam logic [PC_W-1:0] PC_INC     = 32'd4;

  function automatic cnt2_e cnt2_next(input cnt2_e s, input logic taken);
    logic [1:0] v;
    v = s;
    if (taken) begin
      if (s != CNT_ST) v = v + 2'd1;
    end else begin
      if (s != CNT_SNT) v = v - 2'd1;
    end
    return cnt2_e'(v);
  endfunction

  function automatic logic cnt2_is_sat(input cnt2_e s);
    return (s == CNT_SNT) || (s == CNT_ST);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating direction counter, one instance per BHT entry.
//   state   | meaning
//   CNT_SNT | strongly not-taken
//   CNT_WNT | weakly not-taken (reset)
//   CNT_WT  | weakly taken
//   CNT_ST  | strongly taken
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_taken,
  output logic [1:0] o_state
);

  cnt2_e r_state;
  cnt2_e w_state_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= BHT_RESET_STATE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_en) w_state_nxt = cnt2_next(r_state, i_taken);
  end

  always_comb begin
    o_state = r_state;
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage bimodal BHT plus tagged jalr target buffer, trained from the EX update port.
// Define BRANCH_PREDICTOR_PERF_EN to add the branch/flush/saturation performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int JTB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [PC_W-1:0] i_if_pc,
  input  logic            i_if_B_type,
  input  logic            i_if_jalr,
  output logic            o_B_type_prediction_result,
  output logic [PC_W-1:0] o_jalr_jump_pc,
  input  logic            i_upd_B_type,
  input  logic            i_upd_taken,
  input  logic            i_upd_jalr,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic [PC_W-1:0] i_upd_jalr_target,
  input  logic            i_PL_flush
`ifdef BRANCH_PREDICTOR_PERF_EN
  ,
  output logic [CNT_W-1:0] o_perf_branch_cnt,
  output logic [CNT_W-1:0] o_perf_flush_cnt,
  output logic [CNT_W-1:0] o_perf_bht_sat_cnt
`endif
);

  localparam int BHT_N     = 1 << BHT_IDX_W;
  localparam int JTB_N     = 1 << JTB_IDX_W;
  localparam int JTB_TAG_W = PC_W - JTB_IDX_W - PC_IDX_LSB;

  logic [BHT_IDX_W-1:0] w_if_bht_idx;
  logic [BHT_IDX_W-1:0] w_upd_bht_idx;
  logic [JTB_IDX_W-1:0] w_if_jtb_idx;
  logic [JTB_IDX_W-1:0] w_upd_jtb_idx;
  logic [JTB_TAG_W-1:0] w_if_jtb_tag;
  logic [JTB_TAG_W-1:0] w_upd_jtb_tag;

  assign w_if_bht_idx  = i_if_pc[BHT_IDX_W+PC_IDX_LSB-1:PC_IDX_LSB];
  assign w_upd_bht_idx = i_upd_pc[BHT_IDX_W+PC_IDX_LSB-1:PC_IDX_LSB];
  assign w_if_jtb_idx  = i_if_pc[JTB_IDX_W+PC_IDX_LSB-1:PC_IDX_LSB];
  assign w_upd_jtb_idx = i_upd_pc[JTB_IDX_W+PC_IDX_LSB-1:PC_IDX_LSB];
  assign w_if_jtb_tag  = i_if_pc[PC_W-1:JTB_IDX_W+PC_IDX_LSB];
  assign w_upd_jtb_tag = i_upd_pc[PC_W-1:JTB_IDX_W+PC_IDX_LSB];

  logic [1:0] w_bht_state [BHT_N];

  for (genvar g = 0; g < BHT_N; g++) begin : g_bht
    sat_counter2 u_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_upd_B_type && (w_upd_bht_idx == BHT_IDX_W'(g))),
      .i_taken (i_upd_taken),
      .o_state (w_bht_state[g])
    );
  end

  logic [JTB_N-1:0]     r_jtb_valid;
  logic [JTB_TAG_W-1:0] r_jtb_tag    [JTB_N];
  logic [PC_W-1:0]      r_jtb_target [JTB_N];

  // Always overwrite: the most recent jalr resolved at an index owns it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_jtb_valid <= '0;
      for (int i = 0; i < JTB_N; i++) begin
        r_jtb_tag[i]    <= '0;
        r_jtb_target[i] <= '0;
      end
    end else if (i_upd_jalr) begin
      r_jtb_valid[w_upd_jtb_idx]  <= 1'b1;
      r_jtb_tag[w_upd_jtb_idx]    <= w_upd_jtb_tag;
      r_jtb_target[w_upd_jtb_idx] <= i_upd_jalr_target;
    end
  end

  logic w_jtb_hit;

  assign w_jtb_hit = i_if_jalr && r_jtb_valid[w_if_jtb_idx]
                     && (r_jtb_tag[w_if_jtb_idx] == w_if_jtb_tag);

  assign o_B_type_prediction_result = i_if_B_type & w_bht_state[w_if_bht_idx][1];
  assign o_jalr_jump_pc             = w_jtb_hit ? r_jtb_target[w_if_jtb_idx]
                                                : i_if_pc + PC_INC;

  logic w_unused_upd_pc_lsb;
  assign w_unused_upd_pc_lsb = ^i_upd_pc[PC_IDX_LSB-1:0];

`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [CNT_W-1:0] r_perf_branch_cnt;
  logic [CNT_W-1:0] r_perf_flush_cnt;
  logic [CNT_W-1:0] r_perf_bht_sat_cnt;
  logic             w_upd_sat;

  // Saturation is judged on the counter value the update leaves behind.
  assign w_upd_sat = i_upd_B_type
                     && cnt2_is_sat(cnt2_next(cnt2_e'(w_bht_state[w_upd_bht_idx]), i_upd_taken));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_branch_cnt  <= '0;
      r_perf_flush_cnt   <= '0;
      r_perf_bht_sat_cnt <= '0;
    end else begin
      if (i_upd_B_type || i_upd_jalr) r_perf_branch_cnt  <= r_perf_branch_cnt + 1'b1;
      if (i_PL_flush)                 r_perf_flush_cnt   <= r_perf_flush_cnt + 1'b1;
      if (w_upd_sat)                  r_perf_bht_sat_cnt <= r_perf_bht_sat_cnt + 1'b1;
    end
  end

  assign o_perf_branch_cnt  = r_perf_branch_cnt;
  assign o_perf_flush_cnt   = r_perf_flush_cnt;
  assign o_perf_bht_sat_cnt = r_perf_bht_sat_cnt;
`else
  localparam int UNUSED_CNT_W = CNT_W;
  logic w_unused_flush;
  assign w_unused_flush = i_PL_flush;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs. a reference model.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] if_pc;
  logic        if_B_type, if_jalr;
  logic        pred;
  logic [31:0] jalr_pc;
  logic        upd_B_type, upd_taken, upd_jalr;
  logic [31:0] upd_pc, upd_tgt;
  logic        pl_flush;
`ifdef BRANCH_PREDICTOR_PERF_EN
  logic [31:0] perf_br, perf_fl, perf_sat;
`endif

  branch_predictor dut (
    .i_clk                      (clk),
    .i_rst                      (rst),
    .i_if_pc                    (if_pc),
    .i_if_B_type                (if_B_type),
    .i_if_jalr                  (if_jalr),
    .o_B_type_prediction_result (pred),
    .o_jalr_jump_pc             (jalr_pc),
    .i_upd_B_type               (upd_B_type),
    .i_upd_taken                (upd_taken),
    .i_upd_jalr                 (upd_jalr),
    .i_upd_pc                   (upd_pc),
    .i_upd_jalr_target          (upd_tgt),
    .i_PL_flush                 (pl_flush)
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    .o_perf_branch_cnt          (perf_br),
    .o_perf_flush_cnt           (perf_fl),
    .o_perf_bht_sat_cnt         (perf_sat)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: counters as plain integers 0..3, JTB remembers the full PC it was trained with.
  int          m_bht  [64];
  bit          m_jv   [16];
  logic [31:0] m_jpc  [16];
  logic [31:0] m_jtgt [16];
  int unsigned m_br, m_fl, m_sat;

  function automatic logic m_pred(input logic [31:0] pc, input logic bt);
    return bt && (m_bht[int'((pc >> 2) % 64)] >= 2);
  endfunction

  function automatic logic [31:0] m_jalr(input logic [31:0] pc, input logic j);
    int i;
    i = int'((pc >> 2) % 16);
    if (j && m_jv[i] && ((m_jpc[i] >> 2) == (pc >> 2))) return m_jtgt[i];
    return pc + 32'd4;
  endfunction

  task automatic tick();
    int i, v;
    if (rst) begin
      for (int k = 0; k < 64; k++) m_bht[k] = 1;
      for (int k = 0; k < 16; k++) m_jv[k] = 0;
      m_br = 0; m_fl = 0; m_sat = 0;
    end else begin
      if (upd_B_type) begin
        i = int'((upd_pc >> 2) % 64);
        v = upd_taken ? m_bht[i] + 1 : m_bht[i] - 1;
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        if (v == 0 || v == 3) m_sat++;
        m_bht[i] = v;
      end
      if (upd_jalr) begin
        i = int'((upd_pc >> 2) % 16);
        m_jv[i] = 1; m_jpc[i] = upd_pc; m_jtgt[i] = upd_tgt;
      end
      if (upd_B_type || upd_jalr) m_br++;
      if (pl_flush) m_fl++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; if_pc = 0; if_B_type = 0; if_jalr = 0;
    upd_B_type = 0; upd_taken = 0; upd_jalr = 0; upd_pc = 0; upd_tgt = 0; pl_flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if_pc = 32'h100; if_B_type = 1; #1;
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", pred); end
    if_B_type = 0; if_jalr = 1; #1;
    checks++; if (jalr_pc !== 32'h104) begin errors++; $display("FAIL reset_jalr: got %h want 00000104", jalr_pc); end
`ifdef BRANCH_PREDICTOR_PERF_EN
    checks++;
    if (perf_br !== 0 || perf_fl !== 0 || perf_sat !== 0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_br, perf_fl, perf_sat);
    end
`endif
    idle();
  endtask

  task automatic test_saturation();
    logic exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    if_pc = 32'h200; if_B_type = 1; upd_pc = 32'h200; upd_B_type = 1;
    for (int n = 0; n < 5; n++) begin
      upd_taken = (n < 3);
      tick();
      checks++;
      if (pred !== exp[n]) begin errors++; $display("FAIL sat_step%0d: got %0b want %0b", n, pred, exp[n]); end
    end
    idle();
  endtask

  task automatic test_jtb();
    do_reset();
    upd_jalr = 1; upd_pc = 32'h40; upd_tgt = 32'h8000;
    tick();
    idle();
    if_pc = 32'h40; if_jalr = 1; #1;
    checks++; if (jalr_pc !== 32'h8000) begin errors++; $display("FAIL jtb_hit: got %h want 00008000", jalr_pc); end
    if_pc = 32'h80; #1;
    checks++; if (jalr_pc !== 32'h84) begin errors++; $display("FAIL jtb_alias: got %h want 00000084", jalr_pc); end
    if_pc = 32'h40; if_jalr = 0; #1;
    checks++; if (jalr_pc !== 32'h44) begin errors++; $display("FAIL jtb_nojalr: got %h want 00000044", jalr_pc); end
    idle();
  endtask

  task automatic test_hazard();
    do_reset();
    if_pc = 32'h300; if_B_type = 1;
    upd_pc = 32'h300; upd_B_type = 1; upd_taken = 1; #1;
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL hazard_same: got %0b want 0", pred); end
    tick();
    upd_B_type = 0; #1;
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL hazard_next: got %0b want 1", pred); end
    idle();
  endtask

  task automatic test_reset_priority();
    do_reset();
    rst = 1; upd_jalr = 1; upd_pc = 32'h40; upd_tgt = 32'h9000;
    tick();
    idle();
    if_pc = 32'h40; if_jalr = 1; #1;
    checks++; if (jalr_pc !== 32'h44) begin errors++; $display("FAIL rstprio_jtb: got %h want 00000044", jalr_pc); end
    idle();
    rst = 1; upd_B_type = 1; upd_taken = 1; upd_pc = 32'h300;
    tick();
    idle();
    if_pc = 32'h300; if_B_type = 1; #1;
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL rstprio_bht: got %0b want 0", pred); end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    if_pc = 32'hFFFF_FFFC; if_jalr = 1; #1;
    checks++; if (jalr_pc !== 32'h0) begin errors++; $display("FAIL wrap: got %h want 00000000", jalr_pc); end
    idle();
  endtask

`ifdef BRANCH_PREDICTOR_PERF_EN
  task automatic test_perf();
    do_reset();
    upd_B_type = 1; upd_taken = 1; upd_pc = 32'h10;
    repeat (3) tick();
    idle();
    upd_jalr = 1; upd_pc = 32'h20; upd_tgt = 32'h1234;
    repeat (2) tick();
    idle();
    pl_flush = 1; tick();
    pl_flush = 0; tick();
    pl_flush = 1; tick();
    idle();
    checks++; if (perf_br !== 32'd5) begin errors++; $display("FAIL perf_branch: got %0d want 5", perf_br); end
    checks++; if (perf_fl !== 32'd2) begin errors++; $display("FAIL perf_flush: got %0d want 2", perf_fl); end
    checks++; if (perf_sat !== 32'd2) begin errors++; $display("FAIL perf_sat: got %0d want 2", perf_sat); end
  endtask
`endif

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FF00 | ($urandom & 32'hFF);
    return (32'($urandom_range(0, 3)) << 8) | ($urandom & 32'hFF);
  endfunction

  task automatic test_random();
    logic        e_pred;
    logic [31:0] e_jalr;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      if_pc      = rand_pc();
      if_B_type  = $urandom_range(0, 1) == 1;
      if_jalr    = $urandom_range(0, 1) == 1;
      upd_B_type = $urandom_range(0, 2) != 0;
      upd_taken  = $urandom_range(0, 1) == 1;
      upd_jalr   = $urandom_range(0, 3) == 0;
      upd_pc     = ($urandom_range(0, 1) == 1) ? if_pc : rand_pc();
      upd_tgt    = $urandom;
      pl_flush   = $urandom_range(0, 3) == 0;
      #1;
      e_pred = m_pred(if_pc, if_B_type);
      e_jalr = m_jalr(if_pc, if_jalr);
      checks++;
      if (pred !== e_pred) begin errors++; $display("FAIL rand_pred[%0d] pc=%h: got %0b want %0b", n, if_pc, pred, e_pred); end
      checks++;
      if (jalr_pc !== e_jalr) begin errors++; $display("FAIL rand_jalr[%0d] pc=%h: got %h want %h", n, if_pc, jalr_pc, e_jalr); end
      tick();
    end
    idle();
`ifdef BRANCH_PREDICTOR_PERF_EN
    checks++; if (perf_br !== m_br) begin errors++; $display("FAIL rand_perf_branch: got %0d want %0d", perf_br, m_br); end
    checks++; if (perf_fl !== m_fl) begin errors++; $display("FAIL rand_perf_flush: got %0d want %0d", perf_fl, m_fl); end
    checks++; if (perf_sat !== m_sat) begin errors++; $display("FAIL rand_perf_sat: got %0d want %0d", perf_sat, m_sat); end
`endif
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_saturation();
    test_jtb();
    test_hazard();
    test_reset_priority();
    test_wrap();
`ifdef BRANCH_PREDICTOR_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage predictor that generates the speculative inputs consumed by the EX-stage branch resolution logic:
  - B_type direction prediction.
  - jalr target prediction.
- Learns from the resolved outcome that EX sends back on the update port, in the same cycle that EX evaluates PL_flush.
- Contents:
  - Bimodal BHT of 2-bit saturating counters.
  - Direct-mapped jalr target buffer (JTB) with tags.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64 counters).
- JTB_IDX_W, 4, log2 of JTB entries (16 entries).
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_pc  in  32  fetch PC being looked up
- if_B_type  in  1  predecode: fetched instr is a branch
- if_jalr  in  1  predecode: fetched instr is jalr
- B_type_prediction_result  out  1  predicted taken (1) / not-taken (0)
- jalr_jump_pc  out  32  predicted jalr target
- upd_B_type  in  1  EX resolved a branch this cycle
- upd_taken  in  1  actual branch outcome
- upd_jalr  in  1  EX resolved a jalr this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_jalr_target  in  32  actual jalr target (jalr_jump_pc_actual)
- PL_flush  in  1  misprediction flush from EX (counters only)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on the rising edge.
- Indexing:
  - BHT index = pc[BHT_IDX_W+1:2].
  - JTB index = pc[JTB_IDX_W+1:2].
  - JTB tag = pc[31:JTB_IDX_W+2].
  - pc[1:0] ignored.
- Lookup (combinational from state registers, zero latency):
  - B_type_prediction_result = bht[idx][1] when if_B_type; otherwise 0.
  - jalr_jump_pc = jtb_target[idx] when if_jalr, valid[idx]=1 and tag matches; otherwise if_pc+4 (mod 2^32).
  - Outputs are defined for any if_pc, even when the predecode bits are 0.
- BHT update, on a clock edge with upd_B_type=1:
  - Counter states 00 SNT, 01 WNT, 10 WT, 11 ST.
  - upd_taken=1: counter increments, saturating at 11.
  - upd_taken=0: counter decrements, saturating at 00.
- JTB update, on a clock edge with upd_jalr=1: entry at index gets valid=1, the tag, and target = upd_jalr_target. This always overwrites (no replacement policy).
- upd_B_type and upd_jalr are never both 1. If they are, both updates are performed independently.
- Same-cycle lookup and update to the same index:
  - Lookup returns the pre-update value (no bypass).
  - The new value is visible from the next cycle.
- Update latency is 1 cycle. State changes only on update-port edges; lookups never modify state.
- Reset values:
  - All BHT counters = 01 (WNT).
  - All JTB valid = 0. Targets and tags reset to 0.
  - Resulting outputs after reset: B_type_prediction_result=0, jalr_jump_pc=if_pc+4.
- Reset mid-operation: rst has priority over any concurrent update. An update presented in the reset cycle is discarded.
- No stall input. The pipeline holds if_pc stable when stalled, so outputs stay stable.

Optional Feature:
- Macro: BRANCH_PREDICTOR_PERF_EN.
- When defined, adds three outputs:
  - perf_branch_cnt  out  CNT_W: increments on every edge with upd_B_type=1 or upd_jalr=1.
  - perf_flush_cnt  out  CNT_W: increments on every edge with PL_flush=1.
  - perf_bht_sat_cnt  out  CNT_W: increments when a BHT update leaves a counter at 00 or 11.
- Counter behaviour: all three wrap modulo 2^CNT_W and reset to 0 on rst.
- When not defined: the ports and logic are absent and PL_flush is unused.

Decomposition:
- Shared package:
  - 2-bit counter encodings (SNT/WNT/WT/ST).
  - BHT_RESET_STATE = WNT.
  - PC_INC = 4.
  - Index/tag slice helper constants.
- One natural sub-module: sat_counter2, a 2-bit saturating counter.
  - Inputs: en, taken.
  - Output: state.
  - Synchronous reset to WNT.
  - Instantiated per BHT entry via generate.
- The JTB stays inline in the top module.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 1 cycle, then if_pc=0x100, if_B_type=1.
  - Required: prediction=0. With if_jalr=1 instead, jalr_jump_pc=0x104.
- Saturation up:
  - Stimulus: 3 updates at upd_pc=0x200 with taken=1.
  - Required: prediction at if_pc=0x200 becomes 1 after the first update. The counter stays at 11 after the third.
  - Then 1 not-taken update: prediction is still 1. A second not-taken update: prediction is 0.
- JTB hit/alias:
  - Stimulus: upd_jalr=1, upd_pc=0x40, target=0x8000.
  - Required: next cycle, if_pc=0x40 with if_jalr=1 gives 0x8000.
  - Aliasing: if_pc=0x80 (same index, different tag) gives 0x84.
- Same-cycle hazard:
  - Stimulus: if_pc=upd_pc=0x300, upd_B_type=1, taken=1, counter at WNT.
  - Required: prediction=0 that cycle, 1 the next cycle.
- Reset priority:
  - Stimulus: rst=1 together with upd_jalr for pc=0x40.
  - Required: the entry stays invalid and the lookup returns 0x44.
- Wrap:
  - Stimulus: if_pc=0xFFFFFFFC, if_jalr=1, JTB miss.
  - Required: jalr_jump_pc=0x00000000.
- PERF_EN builds only:
  - Stimulus: 5 branch updates and 2 PL_flush pulses.
  - Required: perf_branch_cnt=5, perf_flush_cnt=2.
